// File: rtl/alu_arbiter_if.sv
// Handshake and ALU operand bus between two issue stages, the arbiter and the shared ALU.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [2:0]       req0_f;
  logic             resp0_valid, resp0_ready;

  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [2:0]       req1_f;
  logic             resp1_valid, resp1_ready;

  logic [WIDTH-1:0] resp_y;
  logic             resp_zero;

  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_f;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;

  logic             busy;
  logic             grant_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_f, resp0_ready,
    input  req1_valid, req1_a, req1_b, req1_f, resp1_ready,
    input  alu_y, alu_zero,
    output req0_ready, resp0_valid, req1_ready, resp1_valid,
    output resp_y, resp_zero, alu_a, alu_b, alu_f, busy, grant_id
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_f, resp0_ready,
    output req1_valid, req1_a, req1_b, req1_f, resp1_ready,
    output alu_y, alu_zero,
    input  req0_ready, resp0_valid, req1_ready, resp1_valid,
    input  resp_y, resp_zero, alu_a, alu_b, alu_f, busy, grant_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU: IDLE -> EXEC -> RESP,
// round-robin or fixed-priority grant, operands and result held in registers.
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  logic                  last_grant, grant, accept;
  logic [1:0]            req_valid, resp_rdy;
  logic [1:0][WIDTH-1:0] req_a, req_b;
  logic [1:0][2:0]       req_f;

  logic [WIDTH-1:0] alu_a_q, alu_b_q, y_q;
  logic [2:0]       alu_f_q;
  logic             z_q, grant_id_q;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign resp_rdy  = {bus.resp1_ready, bus.resp0_ready};
  assign req_a     = {bus.req1_a, bus.req0_a};
  assign req_b     = {bus.req1_b, bus.req0_b};
  assign req_f     = {bus.req1_f, bus.req0_f};

  // Contested grant alternates from last_grant, which resets to 1 so requester 0 wins first.
  always_comb begin
    grant = 1'b0;
    unique case (req_valid)
      2'b11:   grant = RR_ENABLE ? ~last_grant : 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && req_valid[grant];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_rdy[grant_id_q]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id_q <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_f_q    <= '0;
      y_q        <= '0;
      z_q        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        grant_id_q <= grant;
        alu_a_q    <= req_a[grant];
        alu_b_q    <= req_b[grant];
        alu_f_q    <= req_f[grant];
      end
      // ALU has had the whole EXEC cycle to settle on the registered operands.
      if (state == EXEC) begin
        y_q <= bus.alu_y;
        z_q <= bus.alu_zero;
      end
    end
  end

  assign bus.req0_ready  = accept && !grant;
  assign bus.req1_ready  = accept && grant;
  assign bus.resp0_valid = (state == RESP) && !grant_id_q;
  assign bus.resp1_valid = (state == RESP) && grant_id_q;
  assign bus.resp_y      = y_q;
  assign bus.resp_zero   = z_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_f       = alu_f_q;
  assign bus.busy        = (state != IDLE);
  assign bus.grant_id    = grant_id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance driven directly and a
// fixed-priority instance fed the same requester inputs.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();
  alu_arbiter_if #(.WIDTH(W)) fp ();

  alu_arbiter #(.WIDTH(W), .RR_ENABLE(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_arbiter #(.WIDTH(W), .RR_ENABLE(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(fp));

  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] f);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_y    = alu_fn(bus.alu_a, bus.alu_b, bus.alu_f);
  assign bus.alu_zero = (alu_fn(bus.alu_a, bus.alu_b, bus.alu_f) == '0);
  assign fp.alu_y     = alu_fn(fp.alu_a, fp.alu_b, fp.alu_f);
  assign fp.alu_zero  = (alu_fn(fp.alu_a, fp.alu_b, fp.alu_f) == '0);

  assign fp.req0_valid  = bus.req0_valid;
  assign fp.req0_a      = bus.req0_a;
  assign fp.req0_b      = bus.req0_b;
  assign fp.req0_f      = bus.req0_f;
  assign fp.resp0_ready = bus.resp0_ready;
  assign fp.req1_valid  = bus.req1_valid;
  assign fp.req1_a      = bus.req1_a;
  assign fp.req1_b      = bus.req1_b;
  assign fp.req1_f      = bus.req1_f;
  assign fp.resp1_ready = bus.resp1_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op on requester n and waits for its response; resp ready held high.
  task automatic run_op(input bit n, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f, output logic [W-1:0] y, output logic z,
                        output int lat);
    bit got = 1'b0;
    bit rv  = 1'b0;
    y = '0; z = 1'b0; lat = 0;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    if (n) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_f = f;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_f = f;
    end
    #1;
    for (int i = 0; i < 10 && !got; i++) begin
      if (n ? bus.req1_ready : bus.req0_ready) got = 1'b1;
      else begin @(posedge clk); #2; end
    end
    chk("op_ready_seen", {63'd0, got}, 64'd1);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    lat = 1;
    #1;
    for (int i = 0; i < 10 && !rv; i++) begin
      if (n ? bus.resp1_valid : bus.resp0_valid) begin
        rv = 1'b1; y = bus.resp_y; z = bus.resp_zero;
      end else begin
        @(posedge clk); #2; lat++;
      end
    end
    chk("op_resp_seen", {63'd0, rv}, 64'd1);
    step();
  endtask

  logic [W-1:0] y;
  logic         z;
  int           lat;
  logic [3:0]   ord_rr, ord_fp;
  int           n_rr, n_fp, fp_r1;

  initial begin
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_f = '0; bus.resp0_ready = 0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_f = '0; bus.resp1_ready = 0;

    // Reset state
    step(); step();
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_grant", {63'd0, bus.grant_id}, 64'd0);
    chk("rst_alu_a", {32'd0, bus.alu_a}, 64'd0);
    chk("rst_resp_y", {32'd0, bus.resp_y}, 64'd0);
    chk("rst_rv", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
    rst_n = 1'b1;
    step();

    // 1: 5+3 on requester 0, latency T -> T+2
    bus.req0_valid = 1; bus.req0_a = 5; bus.req0_b = 3; bus.req0_f = 3'b010; bus.resp0_ready = 1;
    #1;
    chk("t1_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    chk("t1_rdy1", {63'd0, bus.req1_ready}, 64'd0);
    step();
    bus.req0_valid = 0;
    #1;
    chk("t1_exec_busy", {63'd0, bus.busy}, 64'd1);
    chk("t1_exec_rv0", {63'd0, bus.resp0_valid}, 64'd0);
    chk("t1_alu_a", {32'd0, bus.alu_a}, 64'd5);
    chk("t1_alu_f", {61'd0, bus.alu_f}, 64'd2);
    step(); #1;
    chk("t1_rv0", {63'd0, bus.resp0_valid}, 64'd1);
    chk("t1_rv1", {63'd0, bus.resp1_valid}, 64'd0);
    chk("t1_y", {32'd0, bus.resp_y}, 64'd8);
    chk("t1_zero", {63'd0, bus.resp_zero}, 64'd0);
    step(); #1;
    chk("t1_idle_busy", {63'd0, bus.busy}, 64'd0);
    chk("t1_idle_rv0", {63'd0, bus.resp0_valid}, 64'd0);
    step();

    // 2: requester 1 alone, SLT then SUB to zero
    run_op(1'b1, 32'd3, 32'd5, 3'b111, y, z, lat);
    chk("t2_slt_y", {32'd0, y}, 64'd1);
    chk("t2_slt_zero", {63'd0, z}, 64'd0);
    chk("t2_grant", {63'd0, bus.grant_id}, 64'd1);
    chk("t2_lat", lat, 64'd2);
    run_op(1'b1, 32'd7, 32'd7, 3'b110, y, z, lat);
    chk("t2_sub_y", {32'd0, y}, 64'd0);
    chk("t2_sub_zero", {63'd0, z}, 64'd1);

    // 3: both valid continuously after a fresh reset
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    bus.req0_valid = 1; bus.req0_a = 2; bus.req0_b = 2; bus.req0_f = 3'b010;
    bus.req1_valid = 1; bus.req1_a = 9; bus.req1_b = 4; bus.req1_f = 3'b110;
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    ord_rr = '0; ord_fp = '0; n_rr = 0; n_fp = 0; fp_r1 = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        ord_rr = {ord_rr[2:0], bus.req1_ready}; n_rr++;
      end
      if (fp.req0_ready || fp.req1_ready) begin
        ord_fp = {ord_fp[2:0], fp.req1_ready}; n_fp++;
      end
      if (fp.req1_ready) fp_r1++;
      step();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    step(); step(); step();
    chk("t3_rr_count", n_rr, 64'd4);
    chk("t3_rr_order", {60'd0, ord_rr}, 64'b0101);
    chk("t3_fp_count", n_fp, 64'd4);
    chk("t3_fp_order", {60'd0, ord_fp}, 64'b0000);
    chk("t3_fp_req1_ready", fp_r1, 64'd0);

    // 4: response stall on requester 0; other ready and req1 must be ignored
    bus.resp0_ready = 0; bus.resp1_ready = 1;
    bus.req0_valid = 1; bus.req0_a = 10; bus.req0_b = 4; bus.req0_f = 3'b110;
    #1;
    chk("t4_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    step();
    bus.req0_valid = 0;
    step();
    bus.req1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_rv0", {63'd0, bus.resp0_valid}, 64'd1);
      chk("t4_hold_y", {32'd0, bus.resp_y}, 64'd6);
      chk("t4_hold_busy", {63'd0, bus.busy}, 64'd1);
      chk("t4_hold_rdy", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      step();
    end
    bus.req1_valid = 0;
    bus.resp0_ready = 1;
    #1;
    chk("t4_release_rv0", {63'd0, bus.resp0_valid}, 64'd1);
    step(); #1;
    chk("t4_idle_busy", {63'd0, bus.busy}, 64'd0);
    chk("t4_idle_rv0", {63'd0, bus.resp0_valid}, 64'd0);
    step();

    // 5: reset during EXEC drops the op
    bus.req0_valid = 1; bus.req0_a = 1; bus.req0_b = 1; bus.req0_f = 3'b010;
    #1;
    chk("t5_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    step();
    bus.req0_valid = 0;
    #1;
    chk("t5_exec_busy", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("t5_rst_alu_a", {32'd0, bus.alu_a}, 64'd0);
    chk("t5_rst_alu_f", {61'd0, bus.alu_f}, 64'd0);
    chk("t5_rst_resp_y", {32'd0, bus.resp_y}, 64'd0);
    chk("t5_rst_rv", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_post_rv", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
      chk("t5_post_busy", {63'd0, bus.busy}, 64'd0);
    end
    run_op(1'b0, 32'd20, 32'd22, 3'b010, y, z, lat);
    chk("t5_next_y", {32'd0, y}, 64'd42);
    chk("t5_next_lat", lat, 64'd2);

    // 6: req1 appears then withdraws while req0 owns the ALU; add wraps to zero
    bus.resp0_ready = 1;
    bus.req0_valid = 1; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'd1; bus.req0_f = 3'b010;
    #1;
    chk("t6_rdy0", {63'd0, bus.req0_ready}, 64'd1);
    step();
    bus.req0_valid = 0;
    bus.req1_valid = 1; bus.req1_a = 32'd100; bus.req1_b = 32'd1; bus.req1_f = 3'b001;
    #1;
    chk("t6_exec_rdy1", {63'd0, bus.req1_ready}, 64'd0);
    step();
    bus.req1_valid = 0;
    #1;
    chk("t6_rv", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd1);
    chk("t6_y", {32'd0, bus.resp_y}, 64'd0);
    chk("t6_zero", {63'd0, bus.resp_zero}, 64'd1);
    step(); step(); #1;
    chk("t6_idle_busy", {63'd0, bus.busy}, 64'd0);
    chk("t6_idle_rdy1", {63'd0, bus.req1_ready}, 64'd0);
    chk("t6_alu_a_held", {32'd0, bus.alu_a}, 64'hFFFF_FFFF);
    chk("t6_grant_held", {63'd0, bus.grant_id}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
